// File: rtl/alu_cmd_reader_if.sv
// Bundles the command byte stream (s_*) and the result stream (m_*) of alu_cmd_reader.
// "slave" is the reader's own view: it consumes the byte stream and produces results.
// "master" is the environment's view: it supplies bytes and accepts results.
interface alu_cmd_reader_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_result;
    logic [2:0]  m_flags;   // {err, carry, zero}
    logic        m_valid;
    logic        m_ready;

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_result, m_flags, m_valid
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_result, m_flags, m_valid
    );
endinterface

// File: rtl/alu_cmd_reader.sv
// Reads 3-byte ALU commands (opcode, A, B) from a byte stream, executes them and
// presents a 16-bit result with {err, carry, zero} flags under full backpressure.
// A command stalled mid-way for TIMEOUT_CYCLES cycles is dropped (0 disables this).
module alu_cmd_reader #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    alu_cmd_reader_if.slave   bus,
    output logic              timeout,
    output logic [7:0]        op_count
);

    typedef enum logic [2:0] {
        GET_OP,
        GET_A,
        GET_B,
        EXEC,
        SEND
    } state_t;

    localparam bit          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CW          = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] STALL_LIMIT = CW'(TIMEOUT_CYCLES);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] stall_cnt;

    logic [2:0]    opcode;
    logic          err_pending;
    logic [7:0]    op_a;
    logic [7:0]    op_b;

    logic          xfer;
    logic          mid_cmd;
    logic          stall_hit;

    logic [15:0]   alu_result;
    logic          alu_carry;
    logic [8:0]    sum9;
    logic [31:0]   shl_wide;
    logic [31:0]   shr_wide;

    // The byte stream is accepted only while collecting command bytes.
    assign bus.s_ready = (state == GET_OP) || (state == GET_A) || (state == GET_B);
    assign xfer        = bus.s_valid && bus.s_ready;
    assign mid_cmd     = (state == GET_A) || (state == GET_B);
    // A transfer on the threshold cycle takes priority over the abort.
    assign stall_hit   = TIMEOUT_EN && mid_cmd && (stall_cnt == STALL_LIMIT) && !xfer;

    // Next-state logic for the command sequencer.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_next = state;
        case (state)
            GET_OP: if (xfer) state_next = GET_A;
            GET_A: begin
                if (xfer)           state_next = GET_B;
                else if (stall_hit) state_next = GET_OP;
            end
            GET_B: begin
                if (xfer)           state_next = EXEC;
                else if (stall_hit) state_next = GET_OP;
            end
            EXEC:   state_next = SEND;
            SEND:   if (bus.m_ready) state_next = GET_OP;
            default: state_next = GET_OP;
        endcase
    end

    // State register, stall counter and abort pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state     <= GET_OP;
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            state   <= state_next;
            timeout <= stall_hit;
            if (xfer || stall_hit || !mid_cmd) begin
                stall_cnt <= '0;
            end else if (TIMEOUT_EN) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    // Capture command bytes as they are transferred.
    always_ff @(posedge clk) begin
        // NOTE: payload registers carry no reset; each one is rewritten before it is used.
        if (xfer) begin
            case (state)
                GET_OP: begin
                    opcode      <= bus.s_data[2:0];
                    err_pending <= (bus.s_data[7:3] != 5'd0);
                end
                GET_A:   op_a <= bus.s_data;
                GET_B:   op_b <= bus.s_data;
                default: ;
            endcase
        end
    end

    // ALU datapath evaluated from the latched command.
    always_comb begin
        alu_result = 16'h0000;
        alu_carry  = 1'b0;
        sum9       = {1'b0, op_a} + {1'b0, op_b};
        shl_wide   = {24'h000000, op_a} << op_b[3:0];
        shr_wide   = {8'h00, op_a, 16'h0000} >> op_b[3:0];
        case (opcode)
            3'd0: begin
                alu_result = {7'b0, sum9};
                alu_carry  = sum9[8];
            end
            3'd1: begin
                alu_result = {8'h00, op_a - op_b};
                alu_carry  = (op_a < op_b);
            end
            3'd2: alu_result = {8'h00, op_a & op_b};
            3'd3: alu_result = {8'h00, op_a | op_b};
            3'd4: alu_result = {8'h00, op_a ^ op_b};
            3'd5: alu_result = {8'h00, op_a} * {8'h00, op_b};
            3'd6: begin
                alu_result = shl_wide[15:0];
                alu_carry  = |shl_wide[31:16];
            end
            3'd7: begin
                alu_result = shr_wide[31:16];
                alu_carry  = |shr_wide[15:0];
            end
            default: ;
        endcase
        if (err_pending) begin
            alu_result = 16'h0000;
            alu_carry  = 1'b0;
        end
    end

    // Result channel registers and completed-command counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.m_valid  <= 1'b0;
            bus.m_result <= 16'h0000;
            bus.m_flags  <= 3'b000;
            op_count     <= 8'd0;
        end else begin
            if (state == EXEC) begin
                bus.m_result <= alu_result;
                bus.m_flags  <= {err_pending, alu_carry, (alu_result == 16'h0000)};
                bus.m_valid  <= 1'b1;
            end else if (state == SEND && bus.m_ready) begin
                bus.m_valid <= 1'b0;
                op_count    <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_reader.sv
// Directed self-checking bench for alu_cmd_reader with a short stall timeout.
module tb_alu_cmd_reader;

    logic       clk;
    logic       reset;
    logic       timeout;
    logic [7:0] op_count;
    int         checks;
    int         errors;
    logic [8:0] wsum;

    alu_cmd_reader_if ifc ();

    alu_cmd_reader #(.TIMEOUT_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (ifc.slave),
        .timeout  (timeout),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte and hold it until the edge that accepts it.
    task automatic send_byte(input logic [7:0] d);
        int n;
        n = 0;
        ifc.s_data  = d;
        ifc.s_valid = 1'b1;
        while (!ifc.s_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ifc.s_ready) check("send_byte.ready_wait", ifc.s_ready, 1);
        @(posedge clk); #1;
        ifc.s_valid = 1'b0;
    endtask

    // Wait (bounded) for a result to be presented.
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!ifc.m_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".valid"}, ifc.m_valid, 1);
    endtask

    // Full command with m_ready high: check result/flags, then let it be consumed.
    task automatic do_cmd(input string tag, input logic [7:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] er, input logic [2:0] ef);
        ifc.m_ready = 1'b1;
        send_byte(op);
        send_byte(a);
        send_byte(b);
        wait_valid(tag);
        check({tag, ".result"}, ifc.m_result, er);
        check({tag, ".flags"}, ifc.m_flags, ef);
        @(posedge clk); #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        ifc.s_data  = 8'h00;
        ifc.s_valid = 1'b0;
        ifc.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst.s_ready",  ifc.s_ready,  1);
        check("rst.m_valid",  ifc.m_valid,  0);
        check("rst.m_result", ifc.m_result, 0);
        check("rst.m_flags",  ifc.m_flags,  0);
        check("rst.timeout",  timeout,      0);
        check("rst.op_count", op_count,     0);

        // ADD with latency: m_valid appears one edge after EXEC, lasts one cycle
        ifc.m_ready = 1'b1;
        send_byte(8'h00);
        send_byte(8'hF0);
        send_byte(8'h20);
        check("add.exec_valid", ifc.m_valid, 0);
        check("add.exec_ready", ifc.s_ready, 0);
        @(posedge clk); #1;
        check("add.valid",  ifc.m_valid,  1);
        check("add.result", ifc.m_result, 16'h0110);
        check("add.flags",  ifc.m_flags,  3'b010);
        @(posedge clk); #1;
        check("add.valid_drop", ifc.m_valid, 0);
        check("add.op_count",   op_count,    1);

        // MUL held under backpressure while a byte waits upstream
        ifc.m_ready = 1'b0;
        send_byte(8'h05);
        send_byte(8'hFF);
        send_byte(8'hFF);
        @(posedge clk); #1;
        ifc.s_data  = 8'hAA;
        ifc.s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("mul.hold_valid",  ifc.m_valid,  1);
            check("mul.hold_result", ifc.m_result, 16'hFE01);
            check("mul.hold_flags",  ifc.m_flags,  3'b000);
            check("mul.hold_sready", ifc.s_ready,  0);
            @(posedge clk); #1;
        end
        ifc.s_valid = 1'b0;
        ifc.m_ready = 1'b1;
        @(posedge clk); #1;
        check("mul.valid_drop", ifc.m_valid, 0);
        check("mul.op_count",   op_count,    2);

        // Remaining opcodes, shifts, and an invalid opcode byte
        do_cmd("sub",  8'h01, 8'h10, 8'h20, 16'h00F0, 3'b010);
        do_cmd("shl",  8'h06, 8'h81, 8'h09, 16'h0200, 3'b010);
        do_cmd("shr",  8'h07, 8'h01, 8'h01, 16'h0000, 3'b011);
        do_cmd("bad",  8'h18, 8'h33, 8'h44, 16'h0000, 3'b101);
        check("bad.op_count", op_count, 6);
        do_cmd("or",   8'h03, 8'h0F, 8'h3C, 16'h003F, 3'b000);
        do_cmd("xor",  8'h04, 8'h0F, 8'h3C, 16'h0033, 3'b000);
        do_cmd("add0", 8'h00, 8'h00, 8'h00, 16'h0000, 3'b001);
        check("ops.op_count", op_count, 9);

        // Timeout: stall after A, abort after the 5th idle edge
        send_byte(8'h01);
        send_byte(8'h05);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("to.quiet", timeout, 0);
        end
        @(posedge clk); #1;
        check("to.pulse", timeout, 1);
        @(posedge clk); #1;
        check("to.pulse_end", timeout, 0);
        check("to.op_count",  op_count, 9);
        do_cmd("to.and", 8'h02, 8'h0F, 8'h3C, 16'h000C, 3'b000);
        check("to.and_op_count", op_count, 10);

        // Transfer on the threshold edge wins over the abort
        send_byte(8'h00);
        send_byte(8'h01);
        repeat (4) begin
            @(posedge clk); #1;
        end
        ifc.s_data  = 8'h02;
        ifc.s_valid = 1'b1;
        @(posedge clk); #1;
        ifc.s_valid = 1'b0;
        check("thr.no_timeout", timeout, 0);
        @(posedge clk); #1;
        check("thr.valid",  ifc.m_valid,  1);
        check("thr.result", ifc.m_result, 16'h0003);
        @(posedge clk); #1;
        check("thr.op_count", op_count, 11);

        // Reset while in GET_B
        send_byte(8'h00);
        send_byte(8'h11);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstb.s_ready",  ifc.s_ready, 1);
        check("rstb.m_valid",  ifc.m_valid, 0);
        check("rstb.op_count", op_count,    0);
        do_cmd("rstb.add", 8'h00, 8'h01, 8'h02, 16'h0003, 3'b000);

        // Reset while in SEND
        ifc.m_ready = 1'b0;
        send_byte(8'h05);
        send_byte(8'h02);
        send_byte(8'h03);
        @(posedge clk); #1;
        check("rsts.pre_valid", ifc.m_valid, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rsts.s_ready",  ifc.s_ready,  1);
        check("rsts.m_valid",  ifc.m_valid,  0);
        check("rsts.m_result", ifc.m_result, 0);
        check("rsts.op_count", op_count,     0);

        // 256 commands wrap op_count back to 0
        for (int i = 0; i < 256; i++) begin
            wsum = {1'b0, 8'(i)} + 9'd1;
            do_cmd("wrap", 8'h00, 8'(i), 8'h01, {7'b0, wsum}, {1'b0, wsum[8], 1'b0});
            if (i == 254) check("wrap.op_count_255", op_count, 255);
        end
        check("wrap.op_count_0", op_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
